// File: rtl/dbu_ctrl_pkg.sv
// Shared definitions for the DBU run/step controller and the DBU display mux:
// state encodings and the state field width.
package dbu_ctrl_pkg;

   localparam int DBU_STATE_W = 2;

   typedef enum logic [DBU_STATE_W-1:0] {
      DBU_PAUSE = 2'd0,
      DBU_RUN   = 2'd1,
      DBU_STEP  = 2'd2,
      DBU_BREAK = 2'd3
   } dbu_state_t;

endpackage

// File: rtl/dbu_ctrl_sync_edge.sv
// Two-flop synchronizer followed by a previous-value flop; rise and any-edge
// pulses are registered so they last exactly one cycle.
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic any
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;
   logic prev_q, prev_d;
   logic rise_q, rise_d;
   logic any_q, any_d;

   always_comb begin
      s1_d   = din;
      s2_d   = s1_q;
      prev_d = s2_q;
      rise_d = s2_q & ~prev_q;
      any_d  = s2_q ^ prev_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
         any_q  <= 1'b0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         prev_q <= prev_d;
         rise_q <= rise_d;
         any_q  <= any_d;
      end
   end

   assign level = s2_q;
   assign rise  = rise_q;
   assign any   = any_q;

endmodule

// File: rtl/dbu_ctrl.sv
// DBU run/step controller: turns succ/step into a per-cycle CPU enable with a
// PC breakpoint, and keeps the debug view address and retired-instruction count.
module dbu_ctrl
   import dbu_ctrl_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   succ,
   input  logic                   step,
   input  logic                   inc,
   input  logic                   dec,
   input  logic                   m_rf,
   input  logic [31:0]            pc,
   input  logic                   bp_en,
   input  logic [31:0]            bp_addr,
   output logic                   cpu_en,
   output logic [ADDR_W-1:0]      m_rf_addr,
   output logic [DBU_STATE_W-1:0] state,
   output logic [CNT_W-1:0]       instr_cnt
);

   logic step_lvl, step_p, step_any;
   logic inc_lvl, inc_p, inc_any;
   logic dec_lvl, dec_p, dec_any;
   logic mrf_lvl, mrf_rise, mrf_chg;
   logic unused_lvl;

   sync_edge u_step (.clk(clk), .rst(rst), .din(step), .level(step_lvl), .rise(step_p),   .any(step_any));
   sync_edge u_inc  (.clk(clk), .rst(rst), .din(inc),  .level(inc_lvl),  .rise(inc_p),    .any(inc_any));
   sync_edge u_dec  (.clk(clk), .rst(rst), .din(dec),  .level(dec_lvl),  .rise(dec_p),    .any(dec_any));
   sync_edge u_mrf  (.clk(clk), .rst(rst), .din(m_rf), .level(mrf_lvl),  .rise(mrf_rise), .any(mrf_chg));

   assign unused_lvl = ^{step_lvl, step_any, inc_lvl, inc_any, dec_lvl, dec_any, mrf_lvl, mrf_rise};

   dbu_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              bp_hit;
   logic              cpu_en_c;

   // A RUN hit withholds the enable so the breakpoint instruction only runs on STEP.
   always_comb begin
      bp_hit   = bp_en && (pc == bp_addr);
      cpu_en_c = ((state_q == DBU_RUN) && !bp_hit) || (state_q == DBU_STEP);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         DBU_PAUSE: begin
            if (succ)        state_d = DBU_RUN;
            else if (step_p) state_d = DBU_STEP;
         end
         DBU_RUN: begin
            if (!succ)       state_d = DBU_PAUSE;
            else if (bp_hit) state_d = DBU_BREAK;
         end
         DBU_STEP: begin
            state_d = succ ? DBU_RUN : DBU_PAUSE;
         end
         DBU_BREAK: begin
            if (step_p)      state_d = DBU_STEP;
            else if (!succ)  state_d = DBU_PAUSE;
         end
         default: state_d = DBU_PAUSE;
      endcase
   end

   always_comb begin
      addr_d = addr_q;
      if (mrf_chg)              addr_d = '0;
      else if (inc_p && dec_p)  addr_d = addr_q;
      else if (inc_p)           addr_d = addr_q + ADDR_W'(1);
      else if (dec_p)           addr_d = addr_q - ADDR_W'(1);
   end

   always_comb begin
      cnt_d = cnt_q;
      if (cpu_en_c) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= DBU_PAUSE;
         addr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign cpu_en    = cpu_en_c;
   assign m_rf_addr = addr_q;
   assign state     = state_q;
   assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_dbu_ctrl.sv
// Directed bench for dbu_ctrl: stimulus pushes cycle-tagged expectations into
// a queue, a negedge monitor pops and compares those due in the current cycle.
module tb_dbu_ctrl;

   logic        clk;
   logic        rst;
   logic        succ;
   logic        step;
   logic        inc;
   logic        dec;
   logic        m_rf;
   logic [31:0] pc;
   logic        bp_en;
   logic [31:0] bp_addr;
   logic        cpu_en;
   logic [7:0]  m_rf_addr;
   logic [1:0]  state;
   logic [15:0] instr_cnt;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // entry: {cycle[31:0], kind[7:0], value[23:0]}; kind 0=state 1=cpu_en 2=addr 3=cnt
   logic [63:0] exp_q[$];

   dbu_ctrl #(.ADDR_W(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .succ(succ), .step(step), .inc(inc), .dec(dec),
      .m_rf(m_rf), .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr),
      .cpu_en(cpu_en), .m_rf_addr(m_rf_addr), .state(state), .instr_cnt(instr_cnt)
   );

   // clock / reset / environment
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // CPU stand-in: PC advances one word per enabled cycle
   always @(posedge clk) begin
      if (rst)         pc <= 32'h0;
      else if (cpu_en) pc <= pc + 32'd4;
   end

   // driver tasks
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_at(input int at, input int kind, input int val);
      logic [63:0] e;
      e = {32'(at), 8'(kind), 24'(val)};
      exp_q.push_back(e);
   endtask

   task automatic expect_se(input int at, input int st, input int en);
      expect_at(at, 0, st);
      expect_at(at, 1, en);
   endtask

   task automatic do_reset();
      rst = 1'b1; succ = 1'b0; step = 1'b0; inc = 1'b0; dec = 1'b0;
      m_rf = 1'b0; bp_en = 1'b0; bp_addr = 32'h0;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic pulse_inc();
      inc = 1'b1;
      tick(1);
      inc = 1'b0;
      tick(1);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      logic [63:0] keep[$];
      logic [23:0] act;
      string       nm;
      keep = {};
      foreach (exp_q[i]) begin
         if (int'(exp_q[i][63:32]) == cyc) begin
            case (exp_q[i][31:24])
               8'd0:    begin act = 24'(state);     nm = "state";     end
               8'd1:    begin act = 24'(cpu_en);    nm = "cpu_en";    end
               8'd2:    begin act = 24'(m_rf_addr); nm = "m_rf_addr"; end
               default: begin act = 24'(instr_cnt); nm = "instr_cnt"; end
            endcase
            checks++;
            if (act !== exp_q[i][23:0]) begin
               errors++;
               $display("FAIL %s cycle %0d got 0x%0h expected 0x%0h", nm, cyc, act, exp_q[i][23:0]);
            end
         end else if (int'(exp_q[i][63:32]) < cyc) begin
            checks++;
            errors++;
            $display("FAIL stale_expectation cycle %0d got none expected check at cycle %0d", cyc, exp_q[i][63:32]);
         end else begin
            keep.push_back(exp_q[i]);
         end
      end
      exp_q = keep;
   end

   // directed stimulus
   initial begin
      int c;
      int d;

      // reset and idle hold
      do_reset();
      c = cyc;
      for (int i = 0; i < 20; i++) begin
         expect_se(c + i, 0, 0);
         expect_at(c + i, 2, 0);
         expect_at(c + i, 3, 0);
      end
      tick(20);

      // single step with step held high for 8 samples
      do_reset();
      c = cyc;
      step = 1'b1;
      expect_se(c + 3, 0, 0);
      expect_se(c + 4, 2, 1);
      expect_at(c + 4, 3, 0);
      expect_se(c + 5, 0, 0);
      expect_at(c + 5, 3, 1);
      for (int i = 6; i <= 13; i++) expect_se(c + i, 0, 0);
      expect_at(c + 13, 3, 1);
      tick(8);
      step = 1'b0;
      tick(7);

      // continuous run for 50 cycles
      do_reset();
      c = cyc;
      succ = 1'b1;
      expect_se(c, 0, 0);
      expect_se(c + 1, 1, 1);
      expect_at(c + 1, 3, 0);
      expect_at(c + 2, 3, 1);
      expect_se(c + 50, 1, 1);
      expect_at(c + 50, 3, 49);
      expect_se(c + 51, 0, 0);
      expect_at(c + 51, 3, 50);
      expect_at(c + 53, 3, 50);
      tick(50);
      succ = 1'b0;
      tick(4);

      // breakpoint at 0x0C, then one step past it
      do_reset();
      c = cyc;
      bp_en = 1'b1;
      bp_addr = 32'h0C;
      succ = 1'b1;
      expect_se(c + 3, 1, 1);
      expect_at(c + 3, 3, 2);
      expect_se(c + 4, 1, 0);
      expect_at(c + 4, 3, 3);
      expect_se(c + 5, 3, 0);
      expect_se(c + 7, 3, 0);
      expect_at(c + 7, 3, 3);
      tick(7);
      d = cyc;
      step = 1'b1;
      expect_se(d + 3, 3, 0);
      expect_se(d + 4, 2, 1);
      expect_at(d + 4, 3, 3);
      expect_se(d + 5, 1, 1);
      expect_at(d + 5, 3, 4);
      tick(1);
      step = 1'b0;
      tick(5);
      succ = 1'b0;
      expect_se(d + 7, 0, 0);
      expect_at(d + 7, 3, 6);
      tick(3);
      bp_en = 1'b0;

      // view address wrap and simultaneous inc/dec
      do_reset();
      c = cyc;
      dec = 1'b1;
      expect_at(c + 3, 2, 0);
      expect_at(c + 4, 2, 255);
      tick(1);
      dec = 1'b0;
      tick(5);
      c = cyc;
      inc = 1'b1;
      expect_at(c + 3, 2, 255);
      expect_at(c + 4, 2, 0);
      tick(1);
      inc = 1'b0;
      tick(5);
      c = cyc;
      inc = 1'b1;
      expect_at(c + 4, 2, 1);
      tick(1);
      inc = 1'b0;
      tick(5);
      c = cyc;
      inc = 1'b1;
      dec = 1'b1;
      expect_at(c + 4, 2, 1);
      expect_at(c + 6, 2, 1);
      tick(1);
      inc = 1'b0;
      dec = 1'b0;
      tick(6);

      // view switch clears the address and wins over inc
      do_reset();
      for (int i = 0; i < 5; i++) pulse_inc();
      tick(4);
      c = cyc;
      expect_at(c, 2, 5);
      m_rf = 1'b1;
      expect_at(c + 3, 2, 5);
      expect_at(c + 4, 2, 0);
      tick(6);
      pulse_inc();
      pulse_inc();
      tick(4);
      c = cyc;
      expect_at(c, 2, 2);
      m_rf = 1'b0;
      inc = 1'b1;
      expect_at(c + 3, 2, 2);
      expect_at(c + 4, 2, 0);
      expect_at(c + 6, 2, 0);
      tick(1);
      inc = 1'b0;
      tick(7);

      foreach (exp_q[i]) begin
         checks++;
         errors++;
         $display("FAIL unchecked_expectation got none expected check at cycle %0d", exp_q[i][63:32]);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
